// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sweep controller: FSM state encoding and
// default widths that must agree with the NCO phase-increment input.
package nco_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NCO_DW      = 8;
  localparam int NCO_DWELL_W = 8;
  localparam int NCO_CNT_W   = 8;

endpackage

// File: rtl/nco_sat_add.sv
// Combinational saturating adder: unsigned value plus signed delta, clamped
// to [0, 2^DW-1], with a flag raised whenever clamping happens.
module nco_sat_add #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] value,
  input  logic [DW-1:0] delta,
  output logic [DW-1:0] sum,
  output logic          sat
);

  logic [DW:0] wide;

  // The carry bit of the DW+1 sum signals underflow when delta is negative
  // and overflow when delta is positive.
  always_comb begin
    wide = {1'b0, value} + {delta[DW-1], delta};
    sat  = wide[DW];
    if (!sat)
      sum = wide[DW-1:0];
    else if (delta[DW-1])
      sum = '0;
    else
      sum = '1;
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear-chirp sequencer feeding the NCO phase increment; one-shot or
// continuous sweeps with per-step dwell, abort and sticky saturation flag.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int DW      = NCO_DW,
  parameter int DWELL_W = NCO_DWELL_W,
  parameter int CNT_W   = NCO_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_mode,
  input  logic [DW-1:0]      i_start_inc,
  input  logic [DW-1:0]      i_step,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [CNT_W-1:0]   i_nsteps,
  output logic [DW-1:0]      o_data,
  output logic               o_load,
  output logic               o_busy,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_step_idx,
  output logic               o_sat
);

  state_t             state, state_n;
  logic [DW-1:0]      start_inc_q, start_inc_n;
  logic [DW-1:0]      step_q, step_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [CNT_W-1:0]   nsteps_q, nsteps_n;
  logic               mode_q, mode_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DW-1:0]      data_n;
  logic               load_n, busy_n, done_n, sat_n;
  logic [CNT_W-1:0]   idx_n;
  logic [DW-1:0]      step_sum;
  logic               step_sat;

  nco_sat_add #(.DW(DW)) u_sat_add (
    .value (o_data),
    .delta (step_q),
    .sum   (step_sum),
    .sat   (step_sat)
  );

  always_comb begin
    state_n     = state;
    start_inc_n = start_inc_q;
    step_n      = step_q;
    dwell_n     = dwell_q;
    nsteps_n    = nsteps_q;
    mode_n      = mode_q;
    cnt_n       = cnt;
    data_n      = o_data;
    idx_n       = o_step_idx;
    sat_n       = o_sat;
    busy_n      = o_busy;
    load_n      = 1'b0;
    done_n      = 1'b0;

    case (state)
      IDLE: begin
        if (i_start && !i_abort) begin
          start_inc_n = i_start_inc;
          step_n      = i_step;
          dwell_n     = i_dwell;
          nsteps_n    = i_nsteps;
          mode_n      = i_mode;
          data_n      = i_start_inc;
          idx_n       = '0;
          cnt_n       = i_dwell;
          sat_n       = 1'b0;
          load_n      = 1'b1;
          busy_n      = 1'b1;
          state_n     = RUN;
        end
      end
      RUN: begin
        // Abort wins over any step or wrap event due in the same cycle.
        if (i_abort) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - DWELL_W'(1);
        end else if (o_step_idx != nsteps_q) begin
          data_n = step_sum;
          sat_n  = o_sat | step_sat;
          idx_n  = o_step_idx + CNT_W'(1);
          cnt_n  = dwell_q;
          load_n = 1'b1;
        end else if (!mode_q) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          data_n = start_inc_q;
          idx_n  = '0;
          cnt_n  = dwell_q;
          load_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      start_inc_q <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      nsteps_q    <= '0;
      mode_q      <= 1'b0;
      cnt         <= '0;
      o_data      <= '0;
      o_load      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_step_idx  <= '0;
      o_sat       <= 1'b0;
    end else begin
      state       <= state_n;
      start_inc_q <= start_inc_n;
      step_q      <= step_n;
      dwell_q     <= dwell_n;
      nsteps_q    <= nsteps_n;
      mode_q      <= mode_n;
      cnt         <= cnt_n;
      o_data      <= data_n;
      o_load      <= load_n;
      o_busy      <= busy_n;
      o_done      <= done_n;
      o_step_idx  <= idx_n;
      o_sat       <= sat_n;
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed test-plan sweeps plus
// randomized sweeps compared cycle by cycle against an arithmetic ramp model.
module tb_nco_sweep_ctrl;

  localparam int DW      = 8;
  localparam int DWELL_W = 8;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start, abort, mode;
  logic [DW-1:0]      start_inc, step;
  logic [DWELL_W-1:0] dwell;
  logic [CNT_W-1:0]   nsteps;
  logic [DW-1:0]      data;
  logic               load, busy, done, sat;
  logic [CNT_W-1:0]   step_idx;

  int checks = 0;
  int errors = 0;

  int ramp [0:255];
  bit rampSat [0:255];

  always #5 clk = ~clk;

  nco_sweep_ctrl #(.DW(DW), .DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_abort     (abort),
    .i_mode      (mode),
    .i_start_inc (start_inc),
    .i_step      (step),
    .i_dwell     (dwell),
    .i_nsteps    (nsteps),
    .o_data      (data),
    .o_load      (load),
    .o_busy      (busy),
    .o_done      (done),
    .o_step_idx  (step_idx),
    .o_sat       (sat)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input int expData, input bit expLoad, input bit expBusy,
                            input bit expDone, input int expIdx, input bit expSat);
    checkOutput({tag, ".data"}, 32'(data), expData);
    checkOutput({tag, ".load"}, 32'(load), 32'(expLoad));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
    checkOutput({tag, ".done"}, 32'(done), 32'(expDone));
    checkOutput({tag, ".idx"},  32'(step_idx), expIdx);
    checkOutput({tag, ".sat"},  32'(sat), 32'(expSat));
  endtask

  // Frequencies of the sweep, computed with unbounded integers then clamped.
  task automatic buildRamp(input int s, input int st, input int n);
    int v;
    ramp[0] = s;
    rampSat[0] = 1'b0;
    for (int i = 1; i <= n; i++) begin
      v = ramp[i-1] + st;
      rampSat[i] = 1'b0;
      if (v < 0) begin
        v = 0;
        rampSat[i] = 1'b1;
      end else if (v > 255) begin
        v = 255;
        rampSat[i] = 1'b1;
      end
      ramp[i] = v;
    end
  endtask

  task automatic applyStimulus(input string tag, input int s, input int st, input int d, input int n,
                               input bit m, input int runCycles, input int abortAt, input bit noise);
    int total, k, kk;
    bit satSoFar;
    buildRamp(s, st, n);
    start_inc = DW'(s);
    step      = DW'(st);
    dwell     = DWELL_W'(d);
    nsteps    = CNT_W'(n);
    mode      = m;
    abort     = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total = m ? runCycles : (n + 1) * (d + 1);
    satSoFar = 1'b0;
    for (int c = 1; c <= total; c++) begin
      k  = (c - 1) / (d + 1);
      kk = k % (n + 1);
      satSoFar = satSoFar | rampSat[kk];
      checkCycle(tag, ramp[kk], ((c - 1) % (d + 1)) == 0, 1'b1, 1'b0, kk, satSoFar);
      if (c == abortAt) begin
        abort = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        checkCycle({tag, ".abort"}, ramp[kk], 1'b0, 1'b0, 1'b0, kk, satSoFar);
        return;
      end
      if (noise) begin
        start     = 1'($urandom_range(0, 1));
        start_inc = DW'($urandom);
        step      = DW'($urandom);
        dwell     = DWELL_W'($urandom);
        nsteps    = CNT_W'($urandom);
        mode      = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkCycle({tag, ".done"}, ramp[n], 1'b0, 1'b0, 1'b1, n, satSoFar);
    @(posedge clk); #1;
    checkCycle({tag, ".idle"}, ramp[n], 1'b0, 1'b0, 1'b0, n, satSoFar);
  endtask

  initial begin
    int s, st, d, n, rc, ab, total;
    bit m;
    rst = 1'b1;
    start = 1'b0; abort = 1'b0; mode = 1'b0;
    start_inc = '0; step = '0; dwell = '0; nsteps = '0;
    #12;
    checkCycle("reset", 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus("ramp", 10, 5, 2, 3, 1'b0, 0, 0, 1'b1);
    applyStimulus("satUp", 250, 4, 0, 2, 1'b0, 0, 0, 1'b0);
    applyStimulus("satDown", 3, -4, 0, 1, 1'b0, 0, 0, 1'b0);
    applyStimulus("cont", 100, -10, 1, 1, 1'b1, 10, 10, 1'b0);
    applyStimulus("abortRamp", 10, 5, 2, 3, 1'b0, 0, 5, 1'b0);
    applyStimulus("restart", 10, 5, 2, 3, 1'b0, 0, 0, 1'b0);

    start = 1'b1; abort = 1'b1; start_inc = 8'd77;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checkCycle("startAbortIdle", 25, 1'b0, 1'b0, 1'b0, 3, 1'b0);

    for (int it = 0; it < 20; it++) begin
      s  = int'($urandom_range(0, 255));
      st = int'($urandom_range(0, 255)) - 128;
      d  = int'($urandom_range(0, 3));
      n  = int'($urandom_range(0, 7));
      m  = 1'($urandom_range(0, 1));
      total = (n + 1) * (d + 1);
      if (m) begin
        rc = int'($urandom_range(5, 40));
        ab = rc;
      end else begin
        rc = 0;
        ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total)) : 0;
      end
      applyStimulus($sformatf("rand%0d", it), s, st, d, n, m, rc, ab, 1'($urandom_range(0, 1)));
    end

    start_inc = 8'd200; step = 8'd3; dwell = 8'd1; nsteps = 8'd5; mode = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    checkCycle("asyncReset", 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus("postReset", 40, 7, 1, 2, 1'b0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep sequencer that drives the phase-increment input of the `nco` block. It latches a start increment, a signed step, a per-step dwell and a step count, then steps the NCO through a linear chirp in one-shot or continuous mode. Its `o_data` connects directly to the NCO `i_data`, with a load strobe and a busy/done handshake toward the host control logic.

## Interface
- `DW`, 8, phase-increment width; must match the NCO `i_data` width
- `DWELL_W`, 8, dwell counter width
- `CNT_W`, 8, step counter width
- `i_clk`  in  1  system clock; all logic is on the rising edge
- `i_reset`  in  1  asynchronous, active-high reset
- `i_start`  in  1  start request, sampled only in IDLE
- `i_abort`  in  1  abort request, effective in RUN
- `i_mode`  in  1  0 = one-shot, 1 = continuous (restart after the last step)
- `i_start_inc`  in  DW  first phase increment (unsigned)
- `i_step`  in  DW  per-step increment delta (two's complement)
- `i_dwell`  in  DWELL_W  each frequency is held for `i_dwell`+1 cycles
- `i_nsteps`  in  CNT_W  the sweep emits `i_nsteps`+1 frequencies
- `o_data`  out  DW  phase increment to the NCO
- `o_load`  out  1  one-cycle pulse in every cycle `o_data` takes a new value
- `o_busy`  out  1  high while in RUN
- `o_done`  out  1  one-cycle pulse at completion of a one-shot sweep
- `o_step_idx`  out  CNT_W  index of the current frequency
- `o_sat`  out  1  sticky flag: at least one step saturated; cleared on start

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE + `i_start` + !`i_abort`:
  - latch all config inputs
  - `o_data`←`i_start_inc`, `o_step_idx`←0, dwell counter←`i_dwell`, `o_sat`←0
  - `o_load`=1, go to RUN
- RUN, dwell counter ≠ 0: decrement the counter; `o_data` holds.
- RUN, dwell counter = 0, `o_step_idx` ≠ latched nsteps:
  - `o_data`←sat(`o_data` + step), `o_step_idx`+1, counter reloaded
  - `o_load`=1
- RUN, counter = 0, last step, mode 0: go to DONE; `o_data` holds its last value.
- RUN, counter = 0, last step, mode 1: `o_data`←latched start_inc, `o_step_idx`←0, counter reloaded, `o_load`=1; stay in RUN.
- DONE: `o_done`=1 for exactly one cycle, then IDLE.
- Saturation arithmetic:
  - compute `o_data` plus sign-extended step at DW+1 bits
  - clamp to 0 on underflow and to 2^DW−1 on overflow
  - set `o_sat` when clamping occurs
- `i_abort` in RUN: next state is IDLE; `o_busy` falls; no `o_done`; `o_data` and `o_step_idx` hold.
- `i_abort` takes priority over a simultaneous step or final-step event.
- `i_start` in RUN or DONE is ignored. `i_start` and `i_abort` together in IDLE: no start.
- Config input changes during RUN have no effect; values latched at start are used.

## Timing
- Reset values: `o_data`=0, `o_load`=0, `o_busy`=0, `o_done`=0, `o_step_idx`=0, `o_sat`=0, state IDLE. Reset takes effect immediately, including mid-sweep.
- All outputs are registered. Start-to-first `o_load` latency is 1 cycle; `o_busy` rises in the same cycle.
- Each frequency is held for exactly `i_dwell`+1 cycles.
- A one-shot sweep lasts (`i_nsteps`+1)(`i_dwell`+1) cycles in RUN, followed by 1 cycle in DONE.
- The earliest restart is the cycle after DONE, when the FSM is back in IDLE.
- `i_dwell`=0: a new value and `o_load` occur every cycle.
- `i_nsteps`=0: a single frequency is emitted, then DONE (mode 0) or a reload every dwell (mode 1).

## Structure
- Shared package `nco_pkg` holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - default width constants `NCO_DW`=8, `NCO_DWELL_W`=8, `NCO_CNT_W`=8
- One sub-module, `nco_sat_add`, which is purely combinational:
  - inputs: unsigned DW value and signed DW delta
  - outputs: clamped sum and a saturation flag
- Everything else is one always block for the FSM and counters.

## Test plan
- One-shot ramp: start_inc=10, step=+5, dwell=2, nsteps=3.
  - `o_data` is 10/15/20/25, each held for 3 cycles; `o_load` at cycles 1, 4, 7, 10
  - `o_done` at cycle 13; `o_busy` high during cycles 1–12
- Saturation: start_inc=250, step=+4, dwell=0, nsteps=2.
  - `o_data` is 250, 254, 255; `o_sat`=1 from the third value
  - a down-sweep with start_inc=3, step=−4 gives 3, 0 with `o_sat`=1
- Continuous mode: start_inc=100, step=−10, dwell=1, nsteps=1.
  - `o_data` repeats 100,100,90,90,100,…; `o_done` is never asserted
- Abort at cycle 5 of the one-shot ramp:
  - `o_busy`=0 at cycle 6, `o_data` holds 15, no `o_done`
  - `i_start` in the next cycle restarts at 10
- Async reset mid-sweep: all outputs return to 0 without waiting for a clock edge. Also, `i_start` pulsed during RUN is ignored, and the sweep timing is unchanged.
